user_axilite_master: RTL
========================

// Module: user_axilite_master
// PURPOSE
//  Single-outstanding AXI4-Lite master; the initiator side of the user register slave.
//  Converts a simple valid/ready command port into AXI4-Lite write or read transactions.
//  Returns one response beat per command. A timeout guard flags a missing B/R.
//  Sits between a local sequencer (e.g. init/poll engine) and the AXI-Lite interconnect.
// PARAMETERS
//  C_ADDR_WIDTH   32    AXI address width
//  C_TIMEOUT      256   cycles allowed from AW+W (or AR) accept to B (or R); 0 disables timeout
//  C_TO_WIDTH     9     timeout counter width, >= clog2(C_TIMEOUT+1)
// PORTS
//  clk             in   1      single clock for all logic
//  rst             in   1      asynchronous active-high reset
//  cmd_valid       in   1      command present
//  cmd_ready       out  1      command accepted when cmd_valid & cmd_ready
//  cmd_rnw         in   1      1=read, 0=write
//  cmd_addr        in   C_ADDR_WIDTH  byte address
//  cmd_wdata       in   32     write data
//  cmd_wstrb       in   4      write byte strobes
//  rsp_valid       out  1      response present
//  rsp_ready       in   1      response consumed when rsp_valid & rsp_ready
//  rsp_rdata       out  32     read data (0 for writes and for timeouts)
//  rsp_resp        out  2      AXI BRESP/RRESP; 2'b10 on timeout
//  rsp_timeout     out  1      1 = slave did not respond in C_TIMEOUT cycles
//  m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready,
//  m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master, data 32
// BEHAVIOUR
//  Reset: all valids/readies low, cmd_ready=0, rsp_* =0, addr/data regs 0, state IDLE.
//  States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN.
//  IDLE: cmd_ready=1. On accept, register addr/data/strb; rnw=0 -> WR_REQ, rnw=1 -> RD_REQ.
//  WR_REQ: awvalid and wvalid asserted together next cycle. Each drops independently on its own
//   handshake; neither drops before handshake. Both done (same or different cycles) -> WR_RESP.
//  WR_RESP: bready=1; on bvalid capture bresp -> RSP.
//  RD_REQ: arvalid=1 until arready -> RD_RESP. RD_RESP: rready=1; on rvalid capture rdata/rresp -> RSP.
//  Latency with zero-wait slave: cmd accept T, AW/W/AR valid T+1, B/R accepted T+2, rsp_valid T+3.
//  RSP: rsp_valid=1, fields stable until rsp_ready; then -> IDLE (cmd_ready high following cycle).
//  One transaction outstanding; no new command accepted until response consumed.
//  Timeout: counter clears on entering WR_RESP/RD_RESP, increments each cycle there. Reaching
//   C_TIMEOUT -> RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, then DRAIN instead of IDLE.
//  Timeout never applies in WR_REQ/RD_REQ (AXI forbids withdrawing valid); those wait forever.
//  DRAIN: bready/rready (matching direction) held 1; late B/R discarded -> IDLE. cmd_ready=0 here.
//  bvalid/rvalid arriving in the same cycle as counter expiry: real response wins, no timeout.
//  rresp/bresp of SLVERR/DECERR passed through unmodified with rsp_timeout=0.
//  Reset mid-transaction: all AXI valids drop asynchronously, state IDLE, pending response lost.
// TESTING
//  Write 0x0000_0010 data 0xA5A5_1234 strb 0xF, zero-wait slave -> AW/W at T+1, rsp_valid T+3, resp 00.
//  Read 0x0000_0008, slave returns 0xDEAD_BEEF after 5 cycles -> rsp_rdata 0xDEAD_BEEF, resp 00.
//  Write with awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held, one B.
//  Read, slave never asserts rvalid, C_TIMEOUT=16 -> rsp at 16 cycles resp 10, timeout 1; late rvalid
//   drained, next command completes normally.
//  rsp_ready held low 10 cycles -> rsp fields stable, cmd_ready stays 0; slave DECERR -> resp 11.
//  Assert rst while awvalid high -> awvalid/wvalid 0 immediately, cmd_ready 1 after reset release.

Source files
------------

// File: rtl/user_axilite_master.sv
// ---------------------------------------------------------------------------
// user_axilite_master
//   Single-outstanding AXI4-Lite master. Turns a valid/ready command port into
//   one AXI4-Lite write (AW+W, B) or read (AR, R) and returns one response
//   beat per command. A timeout guard on the B/R wait reports a missing
//   response; the late beat, if it ever arrives, is drained and discarded.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/ready           command handshake
//   cmd_rnw                   1 = read, 0 = write
//   cmd_addr/wdata/wstrb      byte address, write data, write strobes
//   rsp_valid/ready           response handshake
//   rsp_rdata                 read data (0 for writes and timeouts)
//   rsp_resp                  BRESP/RRESP, 2'b10 on timeout
//   rsp_timeout               slave did not answer within C_TIMEOUT cycles
//   m_axi_*                   AXI4-Lite master channels, 32-bit data
// ---------------------------------------------------------------------------
module user_axilite_master #(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_TIMEOUT    = 256,
    parameter int unsigned C_TO_WIDTH   = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    // command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rnw,
    input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]             cmd_wdata,
    input  logic [3:0]              cmd_wstrb,
    // response port
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    // AXI4-Lite write address
    output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // AXI4-Lite write data
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // AXI4-Lite read address
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    // AXI4-Lite read data
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam bit                    LP_TO_EN   = (C_TIMEOUT != 0);
    localparam logic [C_TO_WIDTH-1:0] LP_TO_LAST = C_TO_WIDTH'(C_TIMEOUT - 1);
    localparam logic [1:0]            LP_SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP,
        ST_DRAIN
    } state_t;

    state_t                  r_state,       w_state_nxt;
    logic                    r_cmd_ready,   w_cmd_ready_nxt;
    logic                    r_rnw,         w_rnw_nxt;
    logic [C_ADDR_WIDTH-1:0] r_addr,        w_addr_nxt;
    logic [31:0]             r_wdata,       w_wdata_nxt;
    logic [3:0]              r_wstrb,       w_wstrb_nxt;
    logic                    r_awvalid,     w_awvalid_nxt;
    logic                    r_wvalid,      w_wvalid_nxt;
    logic                    r_bready,      w_bready_nxt;
    logic                    r_arvalid,     w_arvalid_nxt;
    logic                    r_rready,      w_rready_nxt;
    logic                    r_rsp_valid,   w_rsp_valid_nxt;
    logic [31:0]             r_rsp_rdata,   w_rsp_rdata_nxt;
    logic [1:0]              r_rsp_resp,    w_rsp_resp_nxt;
    logic                    r_rsp_timeout, w_rsp_timeout_nxt;
    logic [C_TO_WIDTH-1:0]   r_to_cnt,      w_to_cnt_nxt;
    logic                    w_to_expire;

    // Last cycle of the response wait; a B/R in this same cycle still wins.
    assign w_to_expire = LP_TO_EN && (r_to_cnt == LP_TO_LAST);

    // State and output registers; reset drops every AXI valid immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_rnw         <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rnw         <= w_rnw_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_wstrb       <= w_wstrb_nxt;
            r_awvalid     <= w_awvalid_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_bready      <= w_bready_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_rready      <= w_rready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_rnw_nxt         = r_rnw;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_wstrb_nxt       = r_wstrb;
        w_awvalid_nxt     = r_awvalid;
        w_wvalid_nxt      = r_wvalid;
        w_bready_nxt      = r_bready;
        w_arvalid_nxt     = r_arvalid;
        w_rready_nxt      = r_rready;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_to_cnt_nxt      = r_to_cnt;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_rnw_nxt       = cmd_rnw;
                    w_addr_nxt      = cmd_addr;
                    w_wdata_nxt     = cmd_wdata;
                    w_wstrb_nxt     = cmd_wstrb;
                    if (cmd_rnw) begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = ST_RD_REQ;
                    end else begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = ST_WR_REQ;
                    end
                end
            end

            // AW and W retire independently; move on once both are gone.
            ST_WR_REQ: begin
                if (r_awvalid && m_axi_awready) w_awvalid_nxt = 1'b0;
                if (r_wvalid && m_axi_wready)   w_wvalid_nxt  = 1'b0;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
                if (m_axi_bvalid) begin
                    w_bready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_resp_nxt    = m_axi_bresp;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = ST_RSP;
                end else if (w_to_expire) begin
                    w_bready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_resp_nxt    = LP_SLVERR;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_RSP;
                end
            end

            ST_RD_REQ: begin
                if (m_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_to_cnt_nxt  = '0;
                    w_state_nxt   = ST_RD_RESP;
                end
            end

            ST_RD_RESP: begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
                if (m_axi_rvalid) begin
                    w_rready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = m_axi_rdata;
                    w_rsp_resp_nxt    = m_axi_rresp;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = ST_RSP;
                end else if (w_to_expire) begin
                    w_rready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_resp_nxt    = LP_SLVERR;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_RSP;
                end
            end

            // After a timeout the slave may still answer, so swallow that beat first.
            ST_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (r_rsp_timeout) begin
                        if (r_rnw) w_rready_nxt = 1'b1;
                        else       w_bready_nxt = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_cmd_ready_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                if (r_rnw ? m_axi_rvalid : m_axi_bvalid) begin
                    w_rready_nxt    = 1'b0;
                    w_bready_nxt    = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule
